cnn_layer_accel_conv_array_sequencer: RTL and testbench
=======================================================

# cnn_layer_accel_conv_array_sequencer

Control-side driver for the convolution array: accepts filter and image beats from upstream valid/ready streams and produces the array's load/stream sequence (count_init pulse, C_MAX_WINDOW_SIZE filter-load beats with i_filter_init, then a counted image stream with img_datain_valid). It sits between the layer's input buffers and the conv array and replaces the hand-written stimulus sequence with synthesizable control. It reports busy while running and pulses done at completion.

## Interface
- C_MAX_WINDOW_SIZE, 3, filter taps per row; number of filter-load beats.
- C_IMG_DATA_WIDTH, 18, bits per image lane.
- C_FILTER_DATA_WIDTH, 18, bits per filter lane.
- C_NUM_PIXELS_WIDTH, 16, width of image beat counter.
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sequence; honoured only in IDLE.
- num_pixels  in  C_NUM_PIXELS_WIDTH  image beats to stream; sampled when start is accepted.
- filter_in_data  in  C_FILTER_DATA_WIDTH*C_MAX_WINDOW_SIZE  filter beat, lane k at [k*W +: W].
- filter_in_valid  in  1  / filter_in_ready  out  1  filter stream handshake.
- img_in_data  in  C_IMG_DATA_WIDTH*C_MAX_WINDOW_SIZE  image beat.
- img_in_valid  in  1  / img_in_ready  out  1  image stream handshake.
- count_init  out  1  one-cycle pulse to array counters.
- pipeline_active  out  1  high from CNT_INIT through DONE.
- i_filter_datain  out  C_FILTER_DATA_WIDTH*C_MAX_WINDOW_SIZE  registered filter beat.
- i_filter_init  out  C_MAX_WINDOW_SIZE  all ones on a valid filter beat, else zero.
- i_img_datain  out  C_IMG_DATA_WIDTH*C_MAX_WINDOW_SIZE  registered image beat.
- img_datain_valid  out  1  qualifies i_img_datain.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CNT_INIT, FLT_LOAD, IMG_STREAM, DONE.
- IDLE: start=1 -> CNT_INIT; latch num_pixels into pix_remaining.
- CNT_INIT: one cycle, count_init=1 -> FLT_LOAD (or IMG_STREAM, see Configuration).
- FLT_LOAD: filter_in_ready=1; each accept (valid&ready) increments filt_cnt; on accept with filt_cnt==C_MAX_WINDOW_SIZE-1 -> IMG_STREAM, or -> DONE when pix_remaining==0.
- IMG_STREAM: img_in_ready=1; each accept decrements pix_remaining; accept with pix_remaining==1 -> DONE.
- DONE: done=1 one cycle -> IDLE; start ignored here.
- Ready signals are state decodes; all other outputs are flops.
- Data registers load only on accept; they hold last value otherwise. i_filter_init / img_datain_valid are zero in gap cycles (upstream valid low); gaps are legal and add no other effect.
- start while busy: ignored, no queuing. num_pixels changes after acceptance: ignored.
- Reset (any time): state IDLE, counters zero, all outputs zero; partial load discarded, no done pulse.

## Timing
- start sampled high at edge ending cycle T -> count_init=1 in T+1, pipeline_active/busy=1 from T+1.
- Input accept in cycle N -> corresponding output beat valid in N+1 (1-cycle latency).
- Continuous valid: filter accepts T+2..T+4, i_filter_init=111 in T+3..T+5; image accepts T+5..T+4+P; img_datain_valid T+6..T+5+P.
- done=1, last img_datain_valid, and final pipeline_active cycle coincide at T+5+P; busy=0 from T+6+P.
- P=0: done at T+5; img_in_ready never asserted.
- Minimum start-to-start spacing: sequence length + 1 (IDLE cycle).

## Configuration
- CONV_SEQ_FILTER_REUSE_EN: when defined, adds input port reuse_filter (1 bit, sampled with start); if 1, CNT_INIT -> IMG_STREAM directly (or DONE if P=0), no filter beats consumed, i_filter_init stays zero. When undefined, port absent and FLT_LOAD always executes.

## Test plan
- Reset: rst_n=0 mid IMG_STREAM with valid high -> all outputs 0 immediately, busy=0, no done; next start runs full sequence.
- Nominal: start, P=4, filter/image valid always high, lanes random 1..10 -> count_init T+1, i_filter_init=111 T+3..T+5 matching beats in order, 4 image beats T+6..T+9, done at T+9.
- Backpressure gaps: filter_in_valid low every other cycle, img_in_valid random 50% -> exactly 3 filter beats and P beats out, zero qualifiers in gaps, data unchanged in gaps.
- P=0 -> 3 filter beats, no img_datain_valid, done at T+5, img_in_ready never 1.
- start held high for whole sequence and num_pixels changed to 9 after T -> single sequence of original P, one done pulse, restart only after IDLE.
- With CONV_SEQ_FILTER_REUSE_EN, reuse_filter=1, P=2 -> filter_in_ready never 1, image beats at T+3..T+4, done at T+4.

Source files
------------

// File: rtl/cnn_layer_accel_conv_array_sequencer.sv
// cnn_layer_accel_conv_array_sequencer
// Drives the conv array through one load/stream sequence per accepted start:
// a count_init pulse, C_MAX_WINDOW_SIZE filter-load beats, then num_pixels
// image beats. Upstream beats are registered with one cycle of latency.
// Optional feature macro: CONV_SEQ_FILTER_REUSE_EN. It adds the reuse_filter
// input, which skips the filter load and keeps the previously loaded taps.
module cnn_layer_accel_conv_array_sequencer #(
  parameter int C_MAX_WINDOW_SIZE   = 3,
  parameter int C_IMG_DATA_WIDTH    = 18,
  parameter int C_FILTER_DATA_WIDTH = 18,
  parameter int C_NUM_PIXELS_WIDTH  = 16
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           start,
  input  logic [C_NUM_PIXELS_WIDTH-1:0]                  num_pixels,
`ifdef CONV_SEQ_FILTER_REUSE_EN
  input  logic                                           reuse_filter,
`endif
  input  logic [C_FILTER_DATA_WIDTH*C_MAX_WINDOW_SIZE-1:0] filter_in_data,
  input  logic                                           filter_in_valid,
  output logic                                           filter_in_ready,
  input  logic [C_IMG_DATA_WIDTH*C_MAX_WINDOW_SIZE-1:0]    img_in_data,
  input  logic                                           img_in_valid,
  output logic                                           img_in_ready,
  output logic                                           count_init,
  output logic                                           pipeline_active,
  output logic [C_FILTER_DATA_WIDTH*C_MAX_WINDOW_SIZE-1:0] i_filter_datain,
  output logic [C_MAX_WINDOW_SIZE-1:0]                   i_filter_init,
  output logic [C_IMG_DATA_WIDTH*C_MAX_WINDOW_SIZE-1:0]    i_img_datain,
  output logic                                           img_datain_valid,
  output logic                                           busy,
  output logic                                           done
);

  localparam int FCW = (C_MAX_WINDOW_SIZE > 1) ? $clog2(C_MAX_WINDOW_SIZE) : 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(C_MAX_WINDOW_SIZE - 1);
  localparam logic [C_NUM_PIXELS_WIDTH-1:0] PIX_ONE = C_NUM_PIXELS_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    CNT_INIT,
    FLT_LOAD,
    IMG_STREAM,
    DONE
  } state_t;

  state_t                          state;
  state_t                          state_nxt;
  logic [FCW-1:0]                  filt_cnt;
  logic [C_NUM_PIXELS_WIDTH-1:0]   pix_remaining;
  logic                            reuse_q;
  logic                            filt_acc;
  logic                            img_acc;

  assign filter_in_ready = (state == FLT_LOAD);
  assign img_in_ready    = (state == IMG_STREAM);
  assign filt_acc        = filter_in_valid & filter_in_ready;
  assign img_acc         = img_in_valid & img_in_ready;

`ifdef CONV_SEQ_FILTER_REUSE_EN
  // Capture the reuse request together with start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reuse_q <= 1'b0;
    end else if (state == IDLE && start) begin
      reuse_q <= reuse_filter;
    end
  end
`else
  assign reuse_q = 1'b0;
`endif

  // Next-state decode of the sequence
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = CNT_INIT;
      end
      CNT_INIT: begin
        if (!reuse_q) state_nxt = FLT_LOAD;
        else if (pix_remaining == '0) state_nxt = DONE;
        else state_nxt = IMG_STREAM;
      end
      FLT_LOAD: begin
        if (filt_acc && filt_cnt == FILT_LAST)
          state_nxt = (pix_remaining == '0) ? DONE : IMG_STREAM;
      end
      IMG_STREAM: begin
        if (img_acc && pix_remaining == PIX_ONE) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and status flags; flags are decoded from the next state
  // so they line up with the state they describe rather than lag it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      filt_cnt        <= '0;
      pix_remaining   <= '0;
      count_init      <= 1'b0;
      pipeline_active <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nxt;
      count_init      <= (state_nxt == CNT_INIT);
      pipeline_active <= (state_nxt != IDLE);
      busy            <= (state_nxt != IDLE);
      done            <= (state_nxt == DONE);
      if (state == IDLE && start) begin
        filt_cnt      <= '0;
        pix_remaining <= num_pixels;
      end else begin
        if (filt_acc) filt_cnt <= filt_cnt + FCW'(1);
        if (img_acc) pix_remaining <= pix_remaining - PIX_ONE;
      end
    end
  end

  // Register accepted beats towards the array; data holds between accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_filter_datain  <= '0;
      i_filter_init    <= '0;
      i_img_datain     <= '0;
      img_datain_valid <= 1'b0;
    end else begin
      i_filter_init    <= filt_acc ? '1 : '0;
      img_datain_valid <= img_acc;
      if (filt_acc) i_filter_datain <= filter_in_data;
      if (img_acc) i_img_datain <= img_in_data;
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_conv_array_sequencer.sv
// Testbench for cnn_layer_accel_conv_array_sequencer: directed vector table,
// reset abort, and randomized sequences against a timeline reference model.
module tb_cnn_layer_accel_conv_array_sequencer;

  localparam int MW   = 3;
  localparam int W    = 18;
  localparam int NPW  = 16;
  localparam int FW   = MW * W;
  localparam int MAXC = 128;
`ifdef CONV_SEQ_FILTER_REUSE_EN
  localparam bit REUSE_BUILT = 1'b1;
`else
  localparam bit REUSE_BUILT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [NPW-1:0] num_pixels;
`ifdef CONV_SEQ_FILTER_REUSE_EN
  logic           reuse_filter;
`endif
  logic [FW-1:0]  filter_in_data;
  logic           filter_in_valid;
  logic           filter_in_ready;
  logic [FW-1:0]  img_in_data;
  logic           img_in_valid;
  logic           img_in_ready;
  logic           count_init;
  logic           pipeline_active;
  logic [FW-1:0]  i_filter_datain;
  logic [MW-1:0]  i_filter_init;
  logic [FW-1:0]  i_img_datain;
  logic           img_datain_valid;
  logic           busy;
  logic           done;

  int tests = 0;
  int fails = 0;
  logic [FW-1:0] last_f;
  logic [FW-1:0] last_i;

  typedef struct {
    int p;
    int fmode;
    int imode;
    bit hold;
    bit reuse;
    int gap;
    int exp_done;
  } vec_t;

  vec_t tbl[10];

  cnn_layer_accel_conv_array_sequencer #(
    .C_MAX_WINDOW_SIZE(MW),
    .C_IMG_DATA_WIDTH(W),
    .C_FILTER_DATA_WIDTH(W),
    .C_NUM_PIXELS_WIDTH(NPW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num_pixels(num_pixels),
`ifdef CONV_SEQ_FILTER_REUSE_EN
    .reuse_filter(reuse_filter),
`endif
    .filter_in_data(filter_in_data),
    .filter_in_valid(filter_in_valid),
    .filter_in_ready(filter_in_ready),
    .img_in_data(img_in_data),
    .img_in_valid(img_in_valid),
    .img_in_ready(img_in_ready),
    .count_init(count_init),
    .pipeline_active(pipeline_active),
    .i_filter_datain(i_filter_datain),
    .i_filter_init(i_filter_init),
    .i_img_datain(i_img_datain),
    .img_datain_valid(img_datain_valid),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] flags();
    return {busy, pipeline_active, count_init, done, filter_in_ready,
            img_in_ready, i_filter_init, img_datain_valid};
  endfunction

  function automatic logic [FW-1:0] rand_beat();
    logic [FW-1:0] b;
    b = '0;
    for (int k = 0; k < MW; k++) b[k*W +: W] = W'($urandom_range(1, 10));
    return b;
  endfunction

  // One cycle with start low: everything idle, data registers hold
  task automatic idle_cycle();
    @(posedge clk);
    #1;
    start           = 1'b0;
    num_pixels      = NPW'($urandom_range(0, 20));
    filter_in_valid = 1'($urandom_range(0, 1));
    img_in_valid    = 1'($urandom_range(0, 1));
    filter_in_data  = rand_beat();
    img_in_data     = rand_beat();
    @(negedge clk);
    chk("idle_flags", 64'(flags()), 64'(10'b0));
    chk("idle_fdata", 64'(i_filter_datain), 64'(last_f));
    chk("idle_idata", 64'(i_img_datain), 64'(last_i));
  endtask

  // Cycle 0 raises start. The model finds the accept cycles from the valid
  // patterns: the first MW filter-valid cycles from cycle 2, then the first
  // p image-valid cycles after that. Every output follows from those cycles.
  task automatic run_seq(input int p, input int fmode, input int imode,
                         input bit hold, input bit reuse, input int abort_at,
                         output int done_at);
    bit            fv[MAXC];
    bit            iv[MAXC];
    bit            facc[MAXC];
    bit            iacc[MAXC];
    logic [FW-1:0] fd[MAXC];
    logic [FW-1:0] id[MAXC];
    int            fa[MW];
    int            ia[16];
    int            n, cc, istart, last, endc;
    bit            r;
    bit            e_fr, e_ir;
    r = reuse && REUSE_BUILT;
    for (int c = 0; c < MAXC; c++) begin
      fv[c]   = (fmode == 0) ? 1'b1 : (fmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      iv[c]   = (imode == 0) ? 1'b1 : (imode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      if (c >= 64) begin
        fv[c] = 1'b1;
        iv[c] = 1'b1;
      end
      fd[c]   = rand_beat();
      id[c]   = rand_beat();
      facc[c] = 1'b0;
      iacc[c] = 1'b0;
    end
    for (int k = 0; k < MW; k++) fa[k] = 0;
    if (!r) begin
      n  = 0;
      cc = 2;
      while (n < MW) begin
        if (fv[cc]) begin
          fa[n]    = cc;
          facc[cc] = 1'b1;
          n++;
        end
        cc++;
      end
      istart = fa[MW-1] + 1;
    end else begin
      istart = 2;
    end
    n  = 0;
    cc = istart;
    while (n < p) begin
      if (iv[cc]) begin
        ia[n]    = cc;
        iacc[cc] = 1'b1;
        n++;
      end
      cc++;
    end
    last    = (p > 0) ? ia[p-1] : (r ? 1 : fa[MW-1]);
    endc    = last + 1;
    done_at = -1;
    for (int c = 0; c <= endc; c++) begin
      @(posedge clk);
      #1;
      start           = (c == 0) ? 1'b1 : (hold ? 1'b1 : 1'($urandom_range(0, 1)));
      num_pixels      = (c == 0) ? NPW'(p) : (hold ? NPW'(9) : NPW'($urandom_range(0, 20)));
`ifdef CONV_SEQ_FILTER_REUSE_EN
      reuse_filter    = (c == 0) ? reuse : 1'($urandom_range(0, 1));
`endif
      filter_in_valid = fv[c];
      filter_in_data  = fd[c];
      img_in_valid    = iv[c];
      img_in_data     = id[c];
      if (c == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        last_f = '0;
        last_i = '0;
        chk("rst_flags", 64'(flags()), 64'(10'b0));
        chk("rst_fdata", 64'(i_filter_datain), 64'(last_f));
        chk("rst_idata", 64'(i_img_datain), 64'(last_i));
        return;
      end
      @(negedge clk);
      if (c >= 1 && facc[c-1]) last_f = fd[c-1];
      if (c >= 1 && iacc[c-1]) last_i = id[c-1];
      e_fr = !r && c >= 2 && c <= fa[MW-1];
      e_ir = p > 0 && c >= istart && c <= last;
      chk("seq_flags", 64'(flags()),
          64'({c >= 1, c >= 1, c == 1, c == endc, e_fr, e_ir,
               (c >= 1 && facc[c-1]) ? 3'b111 : 3'b000, c >= 1 && iacc[c-1]}));
      chk("seq_fdata", 64'(i_filter_datain), 64'(last_f));
      chk("seq_idata", 64'(i_img_datain), 64'(last_i));
      if (done === 1'b1 && done_at < 0) done_at = c;
    end
  endtask

  initial begin
    int d;
    rst_n           = 1'b0;
    start           = 1'b0;
    num_pixels      = '0;
`ifdef CONV_SEQ_FILTER_REUSE_EN
    reuse_filter    = 1'b0;
`endif
    filter_in_data  = '0;
    filter_in_valid = 1'b0;
    img_in_data     = '0;
    img_in_valid    = 1'b0;
    last_f          = '0;
    last_i          = '0;

    //           p fm im hold reuse gap done
    tbl[0] = '{4, 0, 0, 1'b0, 1'b0, 1, 9};
    tbl[1] = '{0, 0, 0, 1'b0, 1'b0, 1, 5};
    tbl[2] = '{1, 0, 0, 1'b0, 1'b0, 1, 6};
    tbl[3] = '{2, 1, 0, 1'b0, 1'b0, 1, 9};
    tbl[4] = '{3, 1, 1, 1'b0, 1'b0, 1, 13};
    tbl[5] = '{0, 1, 0, 1'b0, 1'b0, 1, 7};
    tbl[6] = '{2, 0, 0, 1'b1, 1'b0, 1, 7};
    tbl[7] = '{9, 0, 0, 1'b0, 1'b0, 0, 14};
    tbl[8] = '{2, 0, 0, 1'b0, 1'b1, 1, 4};
    tbl[9] = '{0, 0, 0, 1'b0, 1'b1, 1, 2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", 64'(flags()), 64'(10'b0));
    chk("reset_fdata", 64'(i_filter_datain), 64'(0));
    chk("reset_idata", 64'(i_img_datain), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycle();
    idle_cycle();

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].reuse && !REUSE_BUILT) continue;
      for (int g = 0; g < tbl[i].gap; g++) idle_cycle();
      run_seq(tbl[i].p, tbl[i].fmode, tbl[i].imode, tbl[i].hold, tbl[i].reuse, -1, d);
      chk($sformatf("done_cycle[%0d]", i), 64'(d), 64'(tbl[i].exp_done));
    end

    // Reset in the middle of the image stream with valid high
    idle_cycle();
    run_seq(6, 0, 0, 1'b0, 1'b0, 7, d);
    @(posedge clk);
    #1;
    chk("rst_hold_flags", 64'(flags()), 64'(10'b0));
    rst_n = 1'b1;
    idle_cycle();
    idle_cycle();
    run_seq(3, 0, 0, 1'b0, 1'b0, -1, d);
    chk("post_rst_done", 64'(d), 64'(8));

    // Randomized sequences
    for (int i = 0; i < 25; i++) begin
      int  rp;
      int  rg;
      bit  ru;
      rp = int'($urandom_range(0, 12));
      rg = int'($urandom_range(0, 2));
      ru = REUSE_BUILT ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int g = 0; g < rg; g++) idle_cycle();
      run_seq(rp, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, ru, -1, d);
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
